// File: rtl/sar_pkg.sv
// Shared constants for the successive-approximation search block.
package sar_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PROBE  = 2'd1;
    localparam logic [1:0] VERIFY = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/sar_search_4.sv
// Drives an external comparator MSB-first to find the target on w1; done 2..WIDTH+2 cycles after start.
// No backpressure: start is taken only in IDLE, ignored (not queued) otherwise.
module sar_search_4
    import sar_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] cand_clr;
    logic [WIDTH-1:0] cand_next;
    logic             flags_ok;

    // Exactly one of three flags: odd count, but not all three.
    assign flags_ok = (less ^ equal ^ greater) & ~(less & equal & greater);

    // trial doubles as the running candidate; only bits idx and idx-1 change.
    always_comb begin
        cand_clr = trial;
        if (greater)
            cand_clr[idx] = 1'b0;
        cand_next = cand_clr;
        if (idx != '0)
            cand_next[idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            trial  <= '0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    trial <= '0;
                    busy  <= 1'b0;
                    if (start) begin
                        trial <= MSB_ONLY;
                        idx   <= IW'(WIDTH - 1);
                        found <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= PROBE;
                    end
                end
                PROBE: begin
                    if (!flags_ok) begin
                        err    <= 1'b1;
                        found  <= 1'b0;
                        result <= trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (equal) begin
                        found  <= 1'b1;
                        result <= trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (idx == '0) begin
                        trial <= cand_clr;
                        state <= VERIFY;
                    end else begin
                        idx   <= idx - 1'b1;
                        trial <= cand_next;
                    end
                end
                VERIFY: begin
                    result <= trial;
                    found  <= equal & flags_ok;
                    err    <= ~flags_ok;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    trial <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_4.sv
// Directed bench for sar_search_4 with a behavioural 4-bit comparator on trial/target.
module tb_sar_search_4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       less;
    logic       equal;
    logic       greater;
    logic [3:0] trial;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       found;
    logic       err;

    logic [3:0] target;
    logic       ovr, ovr_l, ovr_e, ovr_g;

    int         total = 0;
    int         bad = 0;
    logic [3:0] seq[$];
    int         n_edges;
    int         n_done;
    logic [3:0] first_result;
    int         inject_at = -1;

    sar_search_4 #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .less    (less),
        .equal   (equal),
        .greater (greater),
        .trial   (trial),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .found   (found),
        .err     (err)
    );

    assign less    = ovr ? ovr_l : (trial < target);
    assign equal   = ovr ? ovr_e : (trial == target);
    assign greater = ovr ? ovr_g : (trial > target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pack_seq();
        logic [31:0] v = '0;
        foreach (seq[i]) v = {v[27:0], seq[i]};
        return v;
    endfunction

    // Pulse start, then follow the search until done or a 20-cycle budget expires.
    task automatic search(input logic [3:0] t);
        target = t;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_edges = 1;
        n_done = 0;
        seq.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) first_result = result;
            start = (i == inject_at);
            if (busy) seq.push_back(trial);
            if (done) begin
                n_done = 1;
                break;
            end
            @(posedge clk);
            n_edges++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++;
        if ({trial, result, busy, done, found, err} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state: got trial=%0d result=%0d busy=%b done=%b found=%b err=%b, want all 0",
                     trial, result, busy, done, found, err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || trial !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b trial=%0d, want 0 0", busy, trial);
        end
    endtask

    task automatic test_target9();
        search(4'd9);
        total++;
        if (pack_seq() !== 32'h8ca9) begin
            bad++;
            $display("FAIL seq_t9: got %h, want 8ca9", pack_seq());
        end
        total++;
        if (n_done !== 1 || n_edges !== 5) begin
            bad++;
            $display("FAIL latency_t9: got done=%0d edges=%0d, want 1 5", n_done, n_edges);
        end
        total++;
        if (result !== 4'd9 || found !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL result_t9: got result=%0d found=%b err=%b, want 9 1 0", result, found, err);
        end
    endtask

    task automatic test_target0();
        search(4'd0);
        total++;
        if (pack_seq() !== 32'h84210) begin
            bad++;
            $display("FAIL seq_t0: got %h, want 84210", pack_seq());
        end
        total++;
        if (n_done !== 1 || n_edges !== 6) begin
            bad++;
            $display("FAIL latency_t0: got done=%0d edges=%0d, want 1 6", n_done, n_edges);
        end
        total++;
        if (result !== 4'd0 || found !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL result_t0: got result=%0d found=%b err=%b, want 0 1 0", result, found, err);
        end
    endtask

    task automatic test_target15();
        search(4'd15);
        total++;
        if (pack_seq() !== 32'h8cef) begin
            bad++;
            $display("FAIL seq_t15: got %h, want 8cef", pack_seq());
        end
        total++;
        if (n_edges !== 5 || result !== 4'd15 || found !== 1'b1) begin
            bad++;
            $display("FAIL result_t15: got edges=%0d result=%0d found=%b, want 5 15 1", n_edges, result, found);
        end
    endtask

    task automatic test_sweep();
        for (int t = 0; t < 16; t++) begin
            search(4'(t));
            total++;
            if (n_done !== 1 || result !== 4'(t) || found !== 1'b1 || err !== 1'b0) begin
                bad++;
                $display("FAIL sweep_%0d: got done=%0d result=%0d found=%b err=%b, want 1 %0d 1 0",
                         t, n_done, result, found, err, t);
            end
        end
    endtask

    task automatic test_err();
        ovr = 1'b1; ovr_l = 1'b1; ovr_e = 1'b1; ovr_g = 1'b0;
        search(4'd6);
        total++;
        if (n_done !== 1 || n_edges !== 2) begin
            bad++;
            $display("FAIL latency_err: got done=%0d edges=%0d, want 1 2", n_done, n_edges);
        end
        total++;
        if (err !== 1'b1 || found !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flags_err: got err=%b found=%b busy=%b, want 1 0 0", err, found, busy);
        end
        ovr = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL after_err: got busy=%b done=%b err=%b, want 0 0 1", busy, done, err);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        target = 4'd9;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (trial !== 4'd12 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_abort: got trial=%0d busy=%b, want 12 1", trial, busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (trial !== 4'd0 || busy !== 1'b0 || result !== 4'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort: got trial=%0d busy=%b result=%0d done=%b, want 0 0 0 0",
                     trial, busy, result, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d done/busy cycles, want 0", dones);
        end
    endtask

    task automatic test_start_while_busy();
        int extra = 0;
        inject_at = 1;
        search(4'd9);
        inject_at = -1;
        total++;
        if (pack_seq() !== 32'h8ca9 || n_edges !== 5 || result !== 4'd9) begin
            bad++;
            $display("FAIL busy_start: got seq=%h edges=%0d result=%0d, want 8ca9 5 9",
                     pack_seq(), n_edges, result);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL busy_start_queued: got %0d extra busy/done cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        search(4'd5);
        total++;
        if (n_done !== 1 || pack_seq() !== 32'h8465 || result !== 4'd5 || found !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got done=%0d seq=%h result=%0d found=%b, want 1 8465 5 1",
                     n_done, pack_seq(), result, found);
        end
        search(4'd3);
        total++;
        if (first_result !== 4'd5) begin
            bad++;
            $display("FAIL b2b_hold: got result=%0d during second search, want 5", first_result);
        end
        total++;
        if (n_done !== 1 || n_edges !== 5 || result !== 4'd3 || found !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: got done=%0d edges=%0d result=%0d found=%b, want 1 5 3 1",
                     n_done, n_edges, result, found);
        end
        repeat (3) @(negedge clk);
        total++;
        if (result !== 4'd3 || found !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_held: got result=%0d found=%b done=%b, want 3 1 0", result, found, done);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        target = 4'd0;
        ovr = 1'b0; ovr_l = 1'b0; ovr_e = 1'b0; ovr_g = 1'b0;
        test_reset();
        test_target9();
        test_target0();
        test_target15();
        test_sweep();
        test_err();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
